bsg_fifo_word_packetizer: RTL

- Sits directly downstream/upstream of the AXI-Lite-to-FIFO adapter on one slot, on the link-side FIFO port.
- TX path: gathers a fixed number of 32-bit host words into one wide packet and presents it to the fabric link with valid/ready.
- RX path: splits a wide packet from the fabric into 32-bit words, LSB word first, for the adapter's receive FIFO.
- Provides word-level status counters for host-visible status registers.

---
 rtl/bsg_fifo_word_packetizer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bsg_fifo_word_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fifo_word_packetizer
// Purpose  : Link-side word/packet converter for one adapter slot.
//            TX: gathers packet_width_p/32 host words (word 0 in the LSBs)
//                into one packet and offers it with valid/ready.
//            RX: splits an incoming packet into 32-bit words, LSB word first.
//            Also exposes word-level occupancy counters for status registers.
// Ports    : clk_i, reset_i (async, active-high)
//            word_v_i/word_data_i/word_rdy_o  TX words in
//            pkt_v_o/pkt_data_o/pkt_rdy_i     TX packet out
//            pkt_v_i/pkt_data_i/pkt_rdy_o     RX packet in
//            word_v_o/word_data_o/word_rdy_i  RX words out
//            tx_words_o, rx_words_o           occupancy counters
// Params   : packet_width_p must be a multiple of 32 and at least 64.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_fifo_word_packetizer #(
  parameter int packet_width_p = 128
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  // TX words in
  input  logic                              word_v_i,
  input  logic [31:0]                       word_data_i,
  output logic                              word_rdy_o,
  // TX packet out
  output logic                              pkt_v_o,
  output logic [packet_width_p-1:0]         pkt_data_o,
  input  logic                              pkt_rdy_i,
  // RX packet in
  input  logic                              pkt_v_i,
  input  logic [packet_width_p-1:0]         pkt_data_i,
  output logic                              pkt_rdy_o,
  // RX words out
  output logic                              word_v_o,
  output logic [31:0]                       word_data_o,
  input  logic                              word_rdy_i,
  // status
  output logic [$clog2(packet_width_p/32+1)-1:0] tx_words_o,
  output logic [$clog2(packet_width_p/32+1)-1:0] rx_words_o
);

  localparam int word_width_lp  = 32;
  localparam int words_lp       = packet_width_p / word_width_lp;
  localparam int count_width_lp = $clog2(words_lp + 1);

  localparam logic [count_width_lp-1:0] c_words = count_width_lp'(words_lp);
  localparam logic [count_width_lp-1:0] c_one   = count_width_lp'(1);

  // --------------------------------------------------------------------------
  // TX assembly: r_tx_cnt is both the fill state and the next word slot.
  // --------------------------------------------------------------------------
  logic [count_width_lp-1:0] r_tx_cnt;
  logic [packet_width_p-1:0] r_tx_data;
  logic                      w_tx_full;
  logic                      w_tx_pkt_hs;
  logic                      w_tx_word_hs;
  logic [count_width_lp-1:0] w_tx_idx;

  assign w_tx_full    = (r_tx_cnt == c_words);
  assign w_tx_pkt_hs  = w_tx_full & pkt_rdy_i;
  // A departing packet frees the register in the same cycle, so a full
  // assembler still takes a word when downstream is ready (zero bubble).
  assign word_rdy_o   = ~w_tx_full | pkt_rdy_i;
  assign w_tx_word_hs = word_v_i & word_rdy_o;
  assign w_tx_idx     = w_tx_pkt_hs ? '0 : r_tx_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_tx_cnt  <= '0;
      r_tx_data <= '0;
    end else begin
      if (w_tx_word_hs) begin
        for (int k = 0; k < words_lp; k++) begin
          if (w_tx_idx == count_width_lp'(k)) begin
            r_tx_data[k*word_width_lp +: word_width_lp] <= word_data_i;
          end
        end
        r_tx_cnt <= w_tx_pkt_hs ? c_one : (r_tx_cnt + c_one);
      end else if (w_tx_pkt_hs) begin
        r_tx_cnt <= '0;
      end
    end
  end

  assign pkt_v_o    = w_tx_full;
  assign pkt_data_o = r_tx_data;
  assign tx_words_o = r_tx_cnt;

  // --------------------------------------------------------------------------
  // RX split: r_rx_cnt counts words still to deliver; the word index is
  // derived from it so the lowest lane leaves first.
  // --------------------------------------------------------------------------
  logic [count_width_lp-1:0] r_rx_cnt;
  logic [packet_width_p-1:0] r_rx_data;
  logic                      w_rx_pkt_hs;
  logic                      w_rx_word_hs;
  logic [count_width_lp-1:0] w_rx_idx;
  logic [word_width_lp-1:0]  w_rx_word;

  assign word_v_o     = (r_rx_cnt != '0);
  // Accept a new packet while empty, or while the final word is leaving.
  assign pkt_rdy_o    = (r_rx_cnt == '0) | ((r_rx_cnt == c_one) & word_rdy_i);
  assign w_rx_pkt_hs  = pkt_v_i & pkt_rdy_o;
  assign w_rx_word_hs = word_v_o & word_rdy_i;
  assign w_rx_idx     = c_words - r_rx_cnt;

  always_comb begin
    w_rx_word = '0;
    for (int k = 0; k < words_lp; k++) begin
      if (w_rx_idx == count_width_lp'(k)) begin
        w_rx_word = r_rx_data[k*word_width_lp +: word_width_lp];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rx_cnt  <= '0;
      r_rx_data <= '0;
    end else begin
      if (w_rx_pkt_hs) begin
        r_rx_data <= pkt_data_i;
        r_rx_cnt  <= c_words;
      end else if (w_rx_word_hs) begin
        r_rx_cnt  <= r_rx_cnt - c_one;
      end
    end
  end

  assign word_data_o = w_rx_word;
  assign rx_words_o  = r_rx_cnt;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (r_tx_cnt <= c_words) else $error("tx_cnt exceeds words_lp");
      assert (r_rx_cnt <= c_words) else $error("rx_cnt exceeds words_lp");
    end
  end
`endif

endmodule
`default_nettype wire
